// File: rtl/proc_subsys_ahb2apb_bridge.sv
// AHB-Lite responder to APB initiator bridge for the proc_subsys peripheral region.
// Optional feature macro: PROC_SUBSYS_AHB2APB_PSTRB_EN (adds the pstrb lane-mask output).

package proj_param_pkg;
  localparam int PROJ_HADDR = 32;
  localparam int PROJ_HDATA = 32;
  localparam int PROJ_PADDR = 16;
  localparam int PROJ_PDATA = 32;
endpackage

module proc_subsys_ahb2apb_bridge #(
  parameter int HADDR = proj_param_pkg::PROJ_HADDR,
  parameter int HDATA = proj_param_pkg::PROJ_HDATA,
  parameter int PADDR = proj_param_pkg::PROJ_PADDR,
  parameter int PDATA = proj_param_pkg::PROJ_PDATA
) (
  input  logic             hclk,
  input  logic             hresetn,
  input  logic             hsel,
  input  logic [HADDR-1:0] haddr,
  input  logic [1:0]       htrans,
  input  logic             hwrite,
  input  logic [2:0]       hsize,
  input  logic [HDATA-1:0] hwdata,
  input  logic             hready,
  output logic             hreadyout,
  output logic             hresp,
  output logic [HDATA-1:0] hrdata,
  output logic             psel,
  output logic             penable,
  output logic [PADDR-1:0] paddr,
  output logic             pwrite,
  output logic [PDATA-1:0] pwdata,
`ifdef PROC_SUBSYS_AHB2APB_PSTRB_EN
  output logic [PDATA/8-1:0] pstrb,
`endif
  input  logic             pready,
  input  logic             pslverr,
  input  logic [PDATA-1:0] prdata
);

  localparam int         NLANE    = PDATA / 8;
  localparam int         LB       = $clog2(NLANE);
  localparam int         LBW      = (LB > 0) ? LB : 1;
  localparam logic [2:0] MAX_SIZE = 3'(LB);

  generate
    if (HDATA != PDATA) begin : g_chk_data
      $fatal(1, "proc_subsys_ahb2apb_bridge: HDATA must equal PDATA");
    end
    if (PADDR > HADDR) begin : g_chk_addr
      $fatal(1, "proc_subsys_ahb2apb_bridge: PADDR must not exceed HADDR");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_ACCESS = 3'd2,
    S_ERR1   = 3'd3,
    S_ERR2   = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             w_accept;
  logic             w_size_ok;
  logic             w_rd_done;
  logic             w_hreadyout_next;
  logic             w_hresp_next;
  logic             w_psel;
  logic             w_penable;
  logic             r_hreadyout;
  logic             r_hresp;
  logic [HDATA-1:0] r_hrdata;
  logic [PADDR-1:0] r_paddr;
  logic             r_pwrite;
  logic             w_unused;

  // Address phases are only taken in IDLE; anything offered in ERR2 is dropped.
  assign w_accept  = (r_state == S_IDLE) & hsel & hready & htrans[1];
  assign w_size_ok = (hsize <= MAX_SIZE);
  assign w_rd_done = (r_state == S_ACCESS) & pready & ~pslverr & ~r_pwrite;

  always_ff @(posedge hclk) begin : p_state_reg
    if (!hresetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin : p_next_state
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next = w_size_ok ? S_SETUP : S_ERR1;
        end
      end
      S_SETUP:  w_state_next = S_ACCESS;
      S_ACCESS: begin
        if (pready) begin
          w_state_next = pslverr ? S_ERR1 : S_IDLE;
        end
      end
      S_ERR1:   w_state_next = S_ERR2;
      S_ERR2:   w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // AHB response flags are decoded from the next state so they land registered.
  always_comb begin : p_output
    w_hreadyout_next = 1'b1;
    w_hresp_next     = 1'b0;
    w_psel           = 1'b0;
    w_penable        = 1'b0;
    case (w_state_next)
      S_SETUP, S_ACCESS: w_hreadyout_next = 1'b0;
      S_ERR1: begin
        w_hreadyout_next = 1'b0;
        w_hresp_next     = 1'b1;
      end
      S_ERR2:  w_hresp_next = 1'b1;
      default: w_hreadyout_next = 1'b1;
    endcase
    case (r_state)
      S_SETUP: w_psel = 1'b1;
      S_ACCESS: begin
        w_psel    = 1'b1;
        w_penable = 1'b1;
      end
      default: w_psel = 1'b0;
    endcase
  end

  always_ff @(posedge hclk) begin : p_datapath
    if (!hresetn) begin
      r_hreadyout <= 1'b1;
      r_hresp     <= 1'b0;
      r_hrdata    <= '0;
      r_paddr     <= '0;
      r_pwrite    <= 1'b0;
    end else begin
      r_hreadyout <= w_hreadyout_next;
      r_hresp     <= w_hresp_next;
      if (w_accept) begin
        r_paddr  <= haddr[PADDR-1:0];
        r_pwrite <= hwrite;
      end
      if (w_rd_done) begin
        r_hrdata <= prdata;
      end
    end
  end

`ifdef PROC_SUBSYS_AHB2APB_PSTRB_EN
  logic [NLANE-1:0] w_strb_dec;
  logic [NLANE-1:0] r_pstrb;

  // A lane is enabled when it sits in the same size-aligned block as the address.
  genvar gi;
  generate
    for (gi = 0; gi < NLANE; gi++) begin : g_lane
      localparam logic [LBW-1:0] LANE = LBW'(gi);
      assign w_strb_dec[gi] = ((LANE >> hsize) == (haddr[LBW-1:0] >> hsize));
    end
  endgenerate

  always_ff @(posedge hclk) begin : p_pstrb
    if (!hresetn) begin
      r_pstrb <= '0;
    end else if (w_accept) begin
      r_pstrb <= hwrite ? w_strb_dec : '0;
    end
  end

  assign pstrb = r_pstrb;
`endif

  generate
    if (HADDR > PADDR) begin : g_unused_hi
      assign w_unused = ^{htrans[0], haddr[HADDR-1:PADDR]};
    end else begin : g_unused_lo
      assign w_unused = htrans[0];
    end
  endgenerate

  // Write data is passed through: the initiator holds hwdata while hreadyout is low.
  assign pwdata    = hwdata;
  assign hreadyout = r_hreadyout;
  assign hresp     = r_hresp;
  assign hrdata    = r_hrdata;
  assign psel      = w_psel;
  assign penable   = w_penable;
  assign paddr     = r_paddr;
  assign pwrite    = r_pwrite;

endmodule

// File: tb/tb_proc_subsys_ahb2apb_bridge.sv
// Scoreboard bench for proc_subsys_ahb2apb_bridge: stimulus queues expectations,
// a negedge monitor checks AHB completions and APB accesses against them.

module tb_proc_subsys_ahb2apb_bridge;
  import proj_param_pkg::*;

  localparam int HA = PROJ_HADDR;
  localparam int HD = PROJ_HDATA;
  localparam int PA = PROJ_PADDR;
  localparam int PD = PROJ_PDATA;
  localparam int SW = PD / 8;

  logic          hclk = 1'b0;
  logic          hresetn;
  logic          hsel;
  logic [HA-1:0] haddr;
  logic [1:0]    htrans;
  logic          hwrite;
  logic [2:0]    hsize;
  logic [HD-1:0] hwdata;
  logic          hready;
  logic          hreadyout;
  logic          hresp;
  logic [HD-1:0] hrdata;
  logic          psel;
  logic          penable;
  logic [PA-1:0] paddr;
  logic          pwrite;
  logic [PD-1:0] pwdata;
  logic          pready;
  logic          pslverr;
  logic [PD-1:0] prdata;
`ifdef PROC_SUBSYS_AHB2APB_PSTRB_EN
  logic [SW-1:0] pstrb;
`endif

  proc_subsys_ahb2apb_bridge dut (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .hsel      (hsel),
    .haddr     (haddr),
    .htrans    (htrans),
    .hwrite    (hwrite),
    .hsize     (hsize),
    .hwdata    (hwdata),
    .hready    (hready),
    .hreadyout (hreadyout),
    .hresp     (hresp),
    .hrdata    (hrdata),
    .psel      (psel),
    .penable   (penable),
    .paddr     (paddr),
    .pwrite    (pwrite),
    .pwdata    (pwdata),
`ifdef PROC_SUBSYS_AHB2APB_PSTRB_EN
    .pstrb     (pstrb),
`endif
    .pready    (pready),
    .pslverr   (pslverr),
    .prdata    (prdata)
  );

  always #5 hclk = ~hclk;

  typedef struct {
    int            issue;
    logic          wr;
    logic [HA-1:0] addr;
    logic          resp;
    logic [HD-1:0] rdata;
    int            waits;
  } ahb_exp_t;

  typedef struct {
    int            issue;
    logic          wr;
    logic [PA-1:0] addr;
    logic [PD-1:0] wdata;
    logic [SW-1:0] strb;
  } apb_exp_t;

  ahb_exp_t ahb_q[$];
  apb_exp_t apb_q[$];
  int       checks = 0;
  int       failures = 0;
  int       cyc = 0;
  int       setup_count = 0;
  int       wait_n = 0;
  int       acc_cnt = 0;

  always @(posedge hclk) cyc <= cyc + 1;

  // APB completer model: pready held low for wait_n ACCESS cycles.
  always @(posedge hclk) acc_cnt <= (psel && penable && !pready) ? acc_cnt + 1 : 0;
  assign pready = (acc_cnt >= wait_n);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge hclk) begin : mon
    ahb_exp_t ea;
    apb_exp_t ep;
    bit       chk_okay_next;
    if (hresetn !== 1'b1) begin
      chk_okay_next = 1'b0;
    end else begin
      if (chk_okay_next) begin
        chk_okay_next = 1'b0;
        chk("post_err_hresp", 32'(hresp), 32'd0);
        chk("post_err_hreadyout", 32'(hreadyout), 32'd1);
      end
      if (ahb_q.size() > 0 && cyc > ahb_q[0].issue && hreadyout === 1'b1) begin
        ea = ahb_q.pop_front();
        $display("AHB %s addr=0x%08h hresp=%0d hrdata=0x%08h waits=%0d",
                 ea.wr ? "WR" : "RD", ea.addr, hresp, hrdata, cyc - ea.issue - 1);
        chk("ahb_wait_states", 32'(cyc - ea.issue - 1), 32'(ea.waits));
        chk("ahb_hresp", 32'(hresp), 32'(ea.resp));
        if (!ea.wr && !ea.resp) chk("ahb_hrdata", hrdata, ea.rdata);
        if (ea.resp) chk_okay_next = 1'b1;
      end
      if (psel === 1'b1 && penable === 1'b0) begin
        setup_count++;
        chk("apb_setup_expected", 32'(apb_q.size() != 0), 32'd1);
        if (apb_q.size() != 0) chk("apb_setup_latency", 32'(cyc - apb_q[0].issue), 32'd1);
      end
      if (psel === 1'b1 && penable === 1'b1 && pready === 1'b1) begin
        chk("apb_access_expected", 32'(apb_q.size() != 0), 32'd1);
        if (apb_q.size() != 0) begin
          ep = apb_q.pop_front();
          $display("APB %s paddr=0x%04h pwdata=0x%08h prdata=0x%08h pslverr=%0d",
                   pwrite ? "WR" : "RD", paddr, pwdata, prdata, pslverr);
          chk("apb_paddr", 32'(paddr), 32'(ep.addr));
          chk("apb_pwrite", 32'(pwrite), 32'(ep.wr));
          if (ep.wr) chk("apb_pwdata", pwdata, ep.wdata);
`ifdef PROC_SUBSYS_AHB2APB_PSTRB_EN
          chk("apb_pstrb", 32'(pstrb), 32'(ep.strb));
`endif
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge hclk);
    #1;
  endtask

  task automatic drive_addr(input logic wr, input logic [HA-1:0] addr, input logic [2:0] size,
                            input logic [HD-1:0] wdata, input logic resp, input logic [HD-1:0] rdata,
                            input int waits, input logic apb, input logic [SW-1:0] strb);
    ahb_exp_t ea;
    apb_exp_t ep;
    hsel = 1'b1; hready = 1'b1; htrans = 2'b10;
    haddr = addr; hwrite = wr; hsize = size;
    ea.issue = cyc; ea.wr = wr; ea.addr = addr; ea.resp = resp; ea.rdata = rdata; ea.waits = waits;
    ahb_q.push_back(ea);
    if (apb) begin
      ep.issue = cyc; ep.wr = wr; ep.addr = addr[PA-1:0]; ep.wdata = wdata; ep.strb = strb;
      apb_q.push_back(ep);
    end
    step(1);
    htrans = 2'b00; hsel = 1'b0; hwdata = wdata;
  endtask

  task automatic wait_done();
    int n = 0;
    while (hreadyout !== 1'b1 && n < 64) begin
      step(1);
      n++;
    end
    if (n >= 64) chk("xfer_timeout_hreadyout", 32'(hreadyout), 32'd1);
  endtask

  task automatic xfer(input logic wr, input logic [HA-1:0] addr, input logic [2:0] size,
                      input logic [HD-1:0] wdata, input logic resp, input logic [HD-1:0] rdata,
                      input int waits, input logic apb, input logic [SW-1:0] strb);
    drive_addr(wr, addr, size, wdata, resp, rdata, waits, apb, strb);
    wait_done();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int sc0;
    int n;
    hresetn = 1'b0; hsel = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0;
    hsize = 3'd2; hwdata = '0; hready = 1'b1; pslverr = 1'b0; prdata = '0;
    step(3);
    chk("rst_psel", 32'(psel), 32'd0);
    chk("rst_penable", 32'(penable), 32'd0);
    chk("rst_hreadyout", 32'(hreadyout), 32'd1);
    chk("rst_hresp", 32'(hresp), 32'd0);
    chk("rst_hrdata", hrdata, 32'd0);
    chk("rst_paddr", 32'(paddr), 32'd0);
    chk("rst_pwrite", 32'(pwrite), 32'd0);
    hresetn = 1'b1;
    step(2);

    // Plain write, zero APB wait states: 2 AHB wait states.
    xfer(1'b1, 32'h0000_1004, 3'd2, 32'hDEAD_BEEF, 1'b0, '0, 2, 1'b1, 4'b1111);
    step(1);

    // Read with pready low for 3 ACCESS cycles: 5 AHB wait states.
    wait_n = 3; prdata = 32'h1234_5678;
    xfer(1'b0, 32'h0000_2000, 3'd2, '0, 1'b0, 32'h1234_5678, 5, 1'b1, 4'b0000);
    wait_n = 0;
    step(1);

    // Write answered with pslverr: ERR1/ERR2 after the APB access.
    pslverr = 1'b1;
    xfer(1'b1, 32'h0000_3000, 3'd2, 32'h0BAD_F00D, 1'b1, '0, 3, 1'b1, 4'b1111);
    pslverr = 1'b0;
    step(1);
    chk("hrdata_hold_after_err", hrdata, 32'h1234_5678);

    // Illegal hsize (doubleword on a 32-bit bus): error without APB access.
    sc0 = setup_count;
    drive_addr(1'b0, 32'h0000_0040, 3'b011, '0, 1'b1, '0, 1, 1'b0, 4'b0000);
    chk("err1_hreadyout", 32'(hreadyout), 32'd0);
    chk("err1_hresp", 32'(hresp), 32'd1);
    wait_done();
    step(2);
    chk("illegal_size_no_apb", 32'(setup_count), 32'(sc0));

    // Back-to-back: read offered in the completion cycle of the write.
    prdata = 32'hCAFE_F00D;
    xfer(1'b1, 32'h0000_0010, 3'd2, 32'hA5A5_0F0F, 1'b0, '0, 2, 1'b1, 4'b1111);
    xfer(1'b0, 32'h0000_0014, 3'd2, '0, 1'b0, 32'hCAFE_F00D, 2, 1'b1, 4'b0000);
    step(1);

    // Address phase offered during ERR2 must be ignored.
    sc0 = setup_count;
    xfer(1'b1, 32'h0000_0050, 3'b011, '0, 1'b1, '0, 1, 1'b0, 4'b0000);
    hsel = 1'b1; hready = 1'b1; htrans = 2'b10; haddr = 32'h0000_0060; hwrite = 1'b1; hsize = 3'd2;
    step(1);
    htrans = 2'b00; hsel = 1'b0;
    step(3);
    chk("err2_addr_ignored", 32'(setup_count), 32'(sc0));
    chk("err2_idle_hreadyout", 32'(hreadyout), 32'd1);

    // Narrow writes: lane mask decoded from hsize and low address bits.
    xfer(1'b1, 32'h0000_0002, 3'd1, 32'h1122_3344, 1'b0, '0, 2, 1'b1, 4'b1100);
    xfer(1'b1, 32'h0000_0103, 3'd0, 32'h5566_7788, 1'b0, '0, 2, 1'b1, 4'b1000);
    step(1);

    // BUSY with hsel, and NONSEQ with hready low: neither starts a transfer.
    sc0 = setup_count;
    hsel = 1'b1; hready = 1'b1; htrans = 2'b01; haddr = 32'h0000_0070; hwrite = 1'b1;
    step(1);
    chk("busy_hreadyout", 32'(hreadyout), 32'd1);
    chk("busy_hresp", 32'(hresp), 32'd0);
    hready = 1'b0; htrans = 2'b10;
    step(1);
    hsel = 1'b0; htrans = 2'b00; hready = 1'b1;
    step(3);
    chk("busy_hready_low_no_apb", 32'(setup_count), 32'(sc0));

    // Reset asserted while ACCESS is stalled.
    wait_n = 5;
    drive_addr(1'b0, 32'h0000_2222, 3'd2, '0, 1'b0, '0, 0, 1'b1, 4'b0000);
    n = 0;
    while (penable !== 1'b1 && n < 20) begin
      step(1);
      n++;
    end
    chk("mid_reset_penable_seen", 32'(penable), 32'd1);
    hresetn = 1'b0;
    step(1);
    ahb_q.delete();
    apb_q.delete();
    chk("mid_reset_psel", 32'(psel), 32'd0);
    chk("mid_reset_penable", 32'(penable), 32'd0);
    chk("mid_reset_hreadyout", 32'(hreadyout), 32'd1);
    chk("mid_reset_hresp", 32'(hresp), 32'd0);
    chk("mid_reset_hrdata", hrdata, 32'd0);
    chk("mid_reset_paddr", 32'(paddr), 32'd0);
    hresetn = 1'b1;
    wait_n = 0;
    step(2);

    // Recovery write; upper haddr bits are dropped on paddr.
    xfer(1'b1, 32'hABCD_0008, 3'd2, 32'h0F1E_2D3C, 1'b0, '0, 2, 1'b1, 4'b1111);
    step(3);

    chk("ahb_queue_drained", 32'(ahb_q.size()), 32'd0);
    chk("apb_queue_drained", 32'(apb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/proc_subsys_ahb2apb_bridge.md
Name: proc_subsys_ahb2apb_bridge

Overview:
- AHB-Lite responder to APB initiator bridge for the proc_subsys peripheral region.
- Accepts single AHB transfers from the subsystem interconnect.
- Converts each one into exactly one APB SETUP/ACCESS sequence.
- Returns read data, OKAY or ERROR to the AHB initiator.
- Widths come from the subsystem verif/param package so the bridge tracks project-wide maxima.

Parameters:
- HADDR, proj_param_pkg::PROJ_HADDR, AHB address width.
- HDATA, proj_param_pkg::PROJ_HDATA, AHB data width; must equal PDATA (elaboration-time fatal otherwise).
- PADDR, proj_param_pkg::PROJ_PADDR, APB address width; must be <= HADDR. paddr = haddr[PADDR-1:0].
- PDATA, proj_param_pkg::PROJ_PDATA, APB data width.

Ports:
- hclk  in  1  clock for both sides.
- hresetn  in  1  reset, synchronous, active-low.
- hsel  in  1  bridge selected.
- haddr  in  HADDR  address-phase address.
- htrans  in  2  transfer type; bit1=1 means NONSEQ/SEQ.
- hwrite  in  1  1=write.
- hsize  in  3  transfer size.
- hwdata  in  HDATA  data-phase write data.
- hready  in  1  bus-level ready (address-phase qualifier).
- hreadyout  out  1  responder ready (registered).
- hresp  out  1  0=OKAY, 1=ERROR (registered).
- hrdata  out  HDATA  read data (registered).
- psel  out  1  APB select.
- penable  out  1  APB enable.
- paddr  out  PADDR  APB address.
- pwrite  out  1  APB direction.
- pwdata  out  PDATA  APB write data.
- pready  in  1  APB ready.
- pslverr  in  1  APB error.
- prdata  in  PDATA  APB read data.

Behaviour:
- Reset values (hresetn low at a hclk edge): state=IDLE, hreadyout=1, hresp=0, hrdata=0, psel=0, penable=0, paddr=0, pwrite=0.
- Reset mid-transfer abandons the APB access immediately; the next cycle shows psel=0.
- Accept condition: state IDLE and hsel & hready & htrans[1].
  - On accept, latch haddr[PADDR-1:0], hwrite and hsize.
- hsel with htrans IDLE/BUSY: zero-wait OKAY, no APB activity.
- FSM states: IDLE, SETUP, ACCESS, ERR1, ERR2.
- IDLE:
  - Accept with legal hsize (hsize <= log2(HDATA/8)) -> SETUP; hreadyout<=0.
  - Accept with illegal hsize -> ERR1 with no APB access.
- SETUP: psel=1, penable=0 -> ACCESS unconditionally.
- ACCESS: psel=1, penable=1. Wait while pready=0; paddr, pwrite and pwdata stay stable.
  - pready & !pslverr -> IDLE. hreadyout<=1, hresp<=0. Reads also latch hrdata<=prdata.
  - pready & pslverr -> ERR1. hrdata is not updated.
- ERR1: hreadyout=0, hresp=1 -> ERR2.
- ERR2: hreadyout=1, hresp=1 -> IDLE.
  - An address phase presented during ERR2 is ignored. The AHB initiator must re-issue it; bench checks no APB access is started.
- pwdata is driven combinationally from hwdata. This is valid because the AHB initiator holds hwdata stable while hreadyout=0.
- Timing, with address phase at cycle A and pready=1 at first ACCESS:
  - SETUP at A+1, ACCESS at A+2.
  - hreadyout=1 at A+3, i.e. 2 wait states.
  - Each extra pready=0 cycle adds 1 wait state.
- Back-to-back: the IDLE cycle with hreadyout=1 completes the previous data phase and may accept the next address phase.
- hrdata holds its last read value across writes and errors.

Optional Feature:
- Macro: PROC_SUBSYS_AHB2APB_PSTRB_EN.
- Defined:
  - Adds output pstrb, width PDATA/8.
  - Writes: pstrb is decoded at accept from hsize and haddr[log2(PDATA/8)-1:0], giving a contiguous, naturally aligned lane mask, e.g. 32-bit halfword at addr 0x2 -> 4'b1100.
  - Reads: pstrb=0. Reset value 0.
- Undefined: no pstrb port. The APB side always sees full-width writes.

Test Plan:
- Write, haddr=0x0000_1004, hwdata=0xDEAD_BEEF, pready tied 1 -> psel at A+1, penable at A+2, paddr=0x1004, pwdata=0xDEADBEEF, hreadyout=1 and hresp=0 at A+3.
- Read 0x0000_2000, prdata=0x1234_5678, pready low 3 cycles -> ACCESS lasts 4 cycles, hreadyout low 5 cycles, hrdata=0x12345678 with OKAY.
- Write with pslverr=1 at pready -> ERR1 (hreadyout=0, hresp=1) then ERR2 (hreadyout=1, hresp=1), then IDLE with hresp=0.
- hsize=3'b011 on 32-bit bus -> ERROR two-cycle response; psel never asserted.
- Back-to-back write 0x10 then read 0x14 -> second address accepted in the completion cycle of the first; two distinct SETUP/ACCESS pairs with no idle APB cycle beyond the required gap.
- hresetn low during ACCESS -> next cycle psel=0, penable=0, hreadyout=1, hresp=0, hrdata=0. With PROC_SUBSYS_AHB2APB_PSTRB_EN defined: halfword write at 0x2 gives pstrb=4'b1100.
